// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: one result bit per cycle,
// start/complete handshake, single-cycle fast path for divide-by-zero and signed overflow.
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            iclk,
    input  logic            irst,
    input  logic            ivalid,
    output logic            oready,
    input  logic [2:0]      ifunct3,
    input  logic [XLEN-1:0] isrca,
    input  logic [XLEN-1:0] isrcb,
    input  logic            iflush,
    output logic            ovalid,
    output logic [XLEN-1:0] oresult
);

    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam int unsigned PW    = 2 * XLEN;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [XLEN-1:0]   opa_q, opa_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN:0]     rem_q, rem_d;
    logic              negq_q, negq_d;
    logic              negr_q, negr_d;
    logic              fast_q, fast_d;
    logic              ovalid_q, ovalid_d;
    logic [XLEN-1:0]   oresult_q, oresult_d;

    // Operand decode on the request inputs
    logic            a_signed, b_signed, sa, sb;
    logic [XLEN-1:0] a_abs, b_abs;
    logic            fast_dz, fast_ov;

    assign a_signed = ifunct3[2] ? ~ifunct3[0] : (ifunct3 != 3'b011);
    assign b_signed = ifunct3[2] ? ~ifunct3[0] : ~ifunct3[1];
    assign sa       = a_signed & isrca[XLEN-1];
    assign sb       = b_signed & isrcb[XLEN-1];
    assign a_abs    = sa ? -isrca : isrca;
    assign b_abs    = sb ? -isrcb : isrcb;
    assign fast_dz  = ifunct3[2] & (isrcb == '0);
    assign fast_ov  = ifunct3[2] & ~ifunct3[0] & (isrca == MIN_NEG) & (&isrcb);

    // Iteration datapath: shift-add for multiply, restoring step for divide
    logic [XLEN:0]   add_sum;
    logic [XLEN+1:0] diff;
    logic [PW-1:0]   prod_fix;
    logic [XLEN-1:0] quo_fix, rem_fix;

    assign add_sum  = {1'b0, acc_q[PW-1:XLEN]} + (acc_q[0] ? {1'b0, opa_q} : '0);
    assign diff     = {rem_q, quo_q[XLEN-1]} - {2'b00, opb_q};
    assign prod_fix = negq_q ? -acc_q : acc_q;
    assign quo_fix  = (negq_q & ~fast_q) ? -quo_q : quo_q;
    assign rem_fix  = (negr_q & ~fast_q) ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        funct3_d  = funct3_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        acc_d     = acc_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        negq_d    = negq_q;
        negr_d    = negr_q;
        fast_d    = fast_q;
        ovalid_d  = 1'b0;
        oresult_d = oresult_q;

        case (state_q)
            S_IDLE: begin
                if (ivalid && !iflush) begin
                    funct3_d = ifunct3;
                    opa_d    = a_abs;
                    opb_d    = b_abs;
                    acc_d    = {{XLEN{1'b0}}, b_abs};
                    negq_d   = sa ^ sb;
                    negr_d   = sa;
                    cnt_d    = CNT_W'(XLEN - 1);
                    if (fast_dz || fast_ov) begin
                        fast_d  = 1'b1;
                        quo_d   = fast_dz ? '1 : isrca;
                        rem_d   = fast_dz ? {1'b0, isrca} : '0;
                        state_d = S_DONE;
                    end else begin
                        fast_d  = 1'b0;
                        quo_d   = a_abs;
                        rem_d   = '0;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (funct3_q[2]) begin
                    if (diff[XLEN+1]) begin
                        rem_d = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
                        quo_d = {quo_q[XLEN-2:0], 1'b0};
                    end else begin
                        rem_d = diff[XLEN:0];
                        quo_d = {quo_q[XLEN-2:0], 1'b1};
                    end
                end else begin
                    acc_d = {add_sum, acc_q[XLEN-1:1]};
                end
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                case (funct3_q)
                    3'b000:                 oresult_d = prod_fix[XLEN-1:0];
                    3'b001, 3'b010, 3'b011: oresult_d = prod_fix[PW-1:XLEN];
                    3'b100, 3'b101:         oresult_d = quo_fix;
                    default:                oresult_d = rem_fix;
                endcase
                ovalid_d = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over everything, leaving the last result in place
        if (iflush) begin
            state_d   = S_IDLE;
            ovalid_d  = 1'b0;
            oresult_d = oresult_q;
        end
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            funct3_q  <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            acc_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            negq_q    <= 1'b0;
            negr_q    <= 1'b0;
            fast_q    <= 1'b0;
            ovalid_q  <= 1'b0;
            oresult_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            funct3_q  <= funct3_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            acc_q     <= acc_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            negq_q    <= negq_d;
            negr_q    <= negr_d;
            fast_q    <= fast_d;
            ovalid_q  <= ovalid_d;
            oresult_q <= oresult_d;
        end
    end

    assign oready  = (state_q == S_IDLE);
    assign ovalid  = ovalid_q;
    assign oresult = oresult_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: 32-bit instance for the main operations and
// abort cases, 8-bit instance for the parametric check.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ivalid, iflush, oready, ovalid;
    logic [2:0]  funct3;
    logic [31:0] srca, srcb, result;
    logic        ivalid8, iflush8, oready8, ovalid8;
    logic [2:0]  funct38;
    logic [7:0]  srca8, srcb8, result8;

    int n_pass  = 0;
    int n_total = 0;
    int lat;
    int seen;
    logic [31:0] res;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32)) dut (
        .iclk(clk), .irst(rst), .ivalid(ivalid), .oready(oready),
        .ifunct3(funct3), .isrca(srca), .isrcb(srcb), .iflush(iflush),
        .ovalid(ovalid), .oresult(result)
    );

    muldiv_unit #(.XLEN(8)) dut8 (
        .iclk(clk), .irst(rst), .ivalid(ivalid8), .oready(oready8),
        .ifunct3(funct38), .isrca(srca8), .isrcb(srcb8), .iflush(iflush8),
        .ovalid(ovalid8), .oresult(result8)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Wait (bounded) for oready, then present one request for exactly one edge (E0)
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        for (int i = 0; i < 80 && !oready; i++) begin
            @(posedge clk); #1;
        end
        ivalid = 1'b1; funct3 = f; srca = a; srcb = b;
        @(posedge clk); #1;
        ivalid = 1'b0;
    endtask

    // Returns edges after E0 until ovalid is seen (0 = timeout)
    task automatic wait_res(output int l, output logic [31:0] r);
        l = 0; r = 'x;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (ovalid) begin
                l = i; r = result;
                break;
            end
        end
    endtask

    task automatic run(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        issue(f, a, b);
        wait_res(lat, res);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_res"}, res, exp);
    endtask

    task automatic count_valid(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (ovalid) cnt++;
        end
    endtask

    task automatic run8(input string tag, input logic [2:0] f, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] exp);
        int l8;
        logic [7:0] r8;
        for (int i = 0; i < 40 && !oready8; i++) begin
            @(posedge clk); #1;
        end
        ivalid8 = 1'b1; funct38 = f; srca8 = a; srcb8 = b;
        @(posedge clk); #1;
        ivalid8 = 1'b0;
        l8 = 0; r8 = 'x;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (ovalid8) begin
                l8 = i; r8 = result8;
                break;
            end
        end
        chk({tag, "_lat"}, 32'(l8), 32'd9);
        chk({tag, "_res"}, 32'(r8), 32'(exp));
    endtask

    initial begin
        rst = 1'b1; ivalid = 1'b0; iflush = 1'b0; funct3 = '0; srca = '0; srcb = '0;
        ivalid8 = 1'b0; iflush8 = 1'b0; funct38 = '0; srca8 = '0; srcb8 = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_oready", 32'(oready), 32'd1);
        chk("rst_ovalid", 32'(ovalid), 32'd0);
        chk("rst_oresult", result, 32'h0);

        // MUL with latency and pulse-width checks
        run("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        chk("mul_oready_with_ovalid", 32'(oready), 32'd1);
        @(posedge clk); #1;
        chk("mul_ovalid_one_cycle", 32'(ovalid), 32'd0);

        run("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        run("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        run("div",    3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run("rem",    3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run("divu",   3'b101, 32'd100, 32'd7, 32'h0000_000E, 33);
        run("remu",   3'b111, 32'd100, 32'd7, 32'h0000_0002, 33);

        // Flush during cycle 10 of a DIV
        issue(3'b100, 32'hFFFF_FFF9, 32'd2);
        repeat (8) begin
            @(posedge clk); #1;
        end
        iflush = 1'b1;
        @(posedge clk); #1;
        iflush = 1'b0;
        chk("flush_oready", 32'(oready), 32'd1);
        chk("flush_ovalid", 32'(ovalid), 32'd0);
        chk("flush_oresult", result, 32'h0000_0002);
        count_valid(40, seen);
        chk("flush_no_result", 32'(seen), 32'd0);

        // Fast path
        run("div_by_zero",  3'b100, 32'h1234, 32'h0, 32'hFFFF_FFFF, 1);
        run("rem_by_zero",  3'b110, 32'h1234, 32'h0, 32'h0000_1234, 1);
        run("div_overflow", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run("rem_overflow", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);

        // Reset during cycle 5 of a MUL
        run("pre_rst_mul", 3'b000, 32'd3, 32'd5, 32'd15, 33);
        issue(3'b000, 32'd9, 32'd9);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid_ovalid", 32'(ovalid), 32'd0);
        chk("rst_mid_oresult", result, 32'h0);
        chk("rst_mid_oready", 32'(oready), 32'd1);
        count_valid(40, seen);
        chk("rst_mid_no_result", 32'(seen), 32'd0);

        // ivalid pulses and operand changes during CALC are ignored
        issue(3'b101, 32'd100, 32'd7);
        repeat (3) begin
            ivalid = 1'b1; funct3 = 3'b000; srca = 32'd3; srcb = 32'd3;
            @(posedge clk); #1;
            ivalid = 1'b0;
        end
        wait_res(lat, res);
        chk("ignore_lat", 32'(lat), 32'd30);
        chk("ignore_res", res, 32'h0000_000E);
        count_valid(40, seen);
        chk("ignore_nothing_queued", 32'(seen), 32'd0);

        // Back-to-back: second request accepted on the edge closing the ovalid cycle
        run("b2b_first", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run("b2b_second", 3'b111, 32'd100, 32'd7, 32'h0000_0002, 33);

        // 8-bit instance
        run8("x8_divu", 3'b101, 8'd200, 8'd9, 8'd22);
        run8("x8_remu", 3'b111, 8'd200, 8'd9, 8'd2);
        run8("x8_mul",  3'b000, 8'h0F, 8'h11, 8'hFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
